uart_tx_sequencer: RTL

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_tx_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_tx_sequencer.sv
// Sends 1..NBYTES_MAX bytes of a latched word to a UART transmitter, one tx_send level per byte.
// First tx_send one cycle after accept; each byte ends on tx_stop, then a fixed low gap; start is ignored while busy.
module uart_tx_sequencer #(
    parameter int NBYTES_MAX = 4,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 20000,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic [2:0]  len,
    input  logic        tx_stop,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [2:0]    NMAX     = 3'(NBYTES_MAX);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, XMIT, GAP, DONE} state_t;

    state_t        state, state_nxt;
    logic [31:0]   word, word_nxt;
    logic [2:0]    remaining, remaining_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [7:0]    tx_data_nxt;
    logic          err_r, err_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic [GW-1:0] gap_cnt, gap_cnt_nxt;
    logic [2:0]    count;
    logic [1:0]    sel;

    always_comb begin
        state_nxt     = state;
        word_nxt      = word;
        remaining_nxt = remaining;
        idx_nxt       = idx;
        tx_data_nxt   = tx_data;
        err_nxt       = err_r;
        count         = (len > NMAX) ? NMAX : len;
        sel           = 2'd0;

        case (state)
            IDLE: begin
                if (start) begin
                    err_nxt = 1'b0;
                    if (len == 3'd0) begin
                        state_nxt = DONE;
                    end else begin
                        sel           = MSB_FIRST ? 2'(count - 3'd1) : 2'd0;
                        word_nxt      = data_in;
                        remaining_nxt = count;
                        idx_nxt       = sel;
                        tx_data_nxt   = data_in[{sel, 3'b000} +: 8];
                        state_nxt     = XMIT;
                    end
                end
            end
            XMIT: begin
                // The first XMIT cycle may still see STOP left over from the previous byte.
                if (tx_stop && (to_cnt != '0)) begin
                    remaining_nxt = remaining - 3'd1;
                    state_nxt     = GAP;
                end else if (to_cnt == TO_LAST) begin
                    remaining_nxt = 3'd0;
                    err_nxt       = 1'b1;
                    state_nxt     = DONE;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (remaining != 3'd0) begin
                        sel         = MSB_FIRST ? (idx - 2'd1) : (idx + 2'd1);
                        idx_nxt     = sel;
                        tx_data_nxt = word[{sel, 3'b000} +: 8];
                        state_nxt   = XMIT;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Both counters restart from zero whenever a state is (re)entered.
        to_cnt_nxt  = (state == XMIT && state_nxt == XMIT) ? to_cnt + TW'(1) : '0;
        gap_cnt_nxt = (state == GAP && state_nxt == GAP) ? gap_cnt + GW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word      <= 32'h0;
            remaining <= 3'd0;
            idx       <= 2'd0;
            tx_data   <= 8'h00;
            err_r     <= 1'b0;
            to_cnt    <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            word      <= word_nxt;
            remaining <= remaining_nxt;
            idx       <= idx_nxt;
            tx_data   <= tx_data_nxt;
            err_r     <= err_nxt;
            to_cnt    <= to_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
        end
    end

    assign tx_send = (state == XMIT);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = done & err_r;

endmodule
